dmem_ctrl: RTL

Parametrised, byte-addressable data memory with a valid/ready request port and a single-cycle response pulse, serving the CPU load/store stage. Supports byte, halfword, word and (at 64-bit width) doubleword accesses, little-endian, with sign or zero extension on loads. Read latency is configurable, and out-of-range accesses are reported with an error flag rather than silently corrupting memory.

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_bank.sv | 50 +++++
 rtl/dmem_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory controller.
// Access size / FSM state enums, size decode and load extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Sign or zero extend the low 8N bits of data to 64 bits.
    function automatic logic [63:0] extend(
        input logic [63:0] data,
        input size_e       size,
        input logic        uns
    );
        logic [63:0] r;
        case (size)
            SZ_B: r = uns ? {56'd0, data[7:0]}
                          : {{56{data[7]}}, data[7:0]};
            SZ_H: r = uns ? {48'd0, data[15:0]}
                          : {{48{data[15]}}, data[15:0]};
            SZ_W: r = uns ? {32'd0, data[31:0]}
                          : {{32{data[31]}}, data[31:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: byte-addressable storage, DATA_W/8 byte lanes per port.
// Lanes are indexed from a base byte address; words preset to INIT_WORD.
module dmem_bank #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_BYTES = 16384,
    parameter logic [31:0] INIT_WORD   = 32'h00000001
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      wmask,
    input  logic [$clog2(DEPTH_BYTES)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH_BYTES)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int ABW   = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;

    // Stored as 32-bit words so the power-up pattern is a plain default.
    logic [31:0] mem [WORDS] = '{default: INIT_WORD};

    logic [ABW-1:0] wa [NB];
    logic [ABW-1:0] ra [NB];

    // Per-lane byte addresses and the little-endian read gather.
    always_comb begin
        wa    = '{default: '0};
        ra    = '{default: '0};
        rdata = '0;
        for (int i = 0; i < NB; i++) begin
            wa[i] = waddr + ABW'(i);
            ra[i] = raddr + ABW'(i);
            rdata[8*i +: 8] =
                mem[ra[i][ABW-1:2]][{ra[i][1:0], 3'b000} +: 8];
        end
    end

    // Byte-enabled write of each active lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we && wmask[i]) begin
                mem[wa[i][ABW-1:2]][{wa[i][1:0], 3'b000} +: 8]
                    <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: valid/ready data memory with sized loads/stores and errors.
// Define DMEM_ALIGN_CHK_EN to flag misaligned accesses as errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_BYTES = 16384,
    parameter int          AW          = 32,
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] INIT_WORD   = 32'h00000001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AW-1:0]     req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB  = DATA_W / 8;
    localparam int ABW = $clog2(DEPTH_BYTES);

    state_e            state;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] ld_q;

    size_e             size;
    logic [3:0]        nbytes;
    logic [AW:0]       last;
    logic              err_size;
    logic              err_range;
    logic              err_align;
    logic              req_err;
    logic              accept;
    logic              bank_we;
    logic [NB-1:0]     wmask;
    logic [DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0] ld_val;

    assign size   = size_e'(req_size);
    assign nbytes = size_bytes(size);
    assign accept = req_valid && req_ready;

    // Request legality: size, range (no wrap) and optional alignment.
    always_comb begin
        last      = {1'b0, req_addr} + (AW+1)'(nbytes - 4'd1);
        err_size  = (size == SZ_D) && (DATA_W == 32);
        err_range = last >= (AW+1)'(DEPTH_BYTES);
`ifdef DMEM_ALIGN_CHK_EN
        err_align = (req_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
`else
        err_align = 1'b0;
`endif
        req_err   = err_size || err_range || err_align;
    end

    // Lane enables for the first N bytes of the access.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++) begin
            wmask[i] = 4'(i) < nbytes;
        end
    end

    // A store landing on a reset edge is not accepted.
    assign bank_we = accept && req_we && !req_err && !rst;

    dmem_bank #(
        .DATA_W      (DATA_W),
        .DEPTH_BYTES (DEPTH_BYTES),
        .INIT_WORD   (INIT_WORD)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .wmask (wmask),
        .waddr (req_addr[ABW-1:0]),
        .wdata (req_wdata),
        .raddr (req_addr[ABW-1:0]),
        .rdata (bank_rdata)
    );

    assign ld_val = DATA_W'(extend(64'(bank_rdata), size, req_unsigned));

    // Request FSM with latency counter and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            cnt       <= '0;
            ld_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else if (RD_LAT == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= ld_val;
                        end else begin
                            state <= WAIT;
                            cnt   <= 2'(RD_LAT - 2);
                            ld_q  <= ld_val;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= ld_q;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
